// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// alu_cmd_sequencer
// Initiator-side driver for a 5-bit signed ALU. Commands arrive over a
// valid/ready interface and are buffered in a DEPTH-entry FIFO. One command
// at a time is issued to the ALU pins. The registered ALU result is captured
// and returned with the command tag over a valid/ready response interface.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b                signed operands
//   cmd_mode                    01 A-group, 10 B-group, 00 nop, 11 illegal
//   cmd_op                      opcode (B-group uses cmd_op[1:0])
//   cmd_tag                     user tag, returned on rsp_tag
//   alu_*                       registered ALU drive pins
//   alu_res                     registered ALU result
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_tag, rsp_err  response payload (rsp_err = illegal mode)
//   busy                        FSM active or FIFO non-empty
//   fifo_count                  current FIFO occupancy
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [4:0]              cmd_a,
  input  logic [4:0]              cmd_b,
  input  logic [1:0]              cmd_mode,
  input  logic [2:0]              cmd_op,
  input  logic [TAG_W-1:0]        cmd_tag,
  output logic [4:0]              alu_a,
  output logic [4:0]              alu_b,
  output logic                    alu_en,
  output logic [2:0]              alu_a_op,
  output logic [1:0]              alu_b_op,
  output logic                    alu_a_en,
  output logic                    alu_b_en,
  input  logic [5:0]              alu_res,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [5:0]              rsp_data,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 15 + TAG_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_wr_entry;
  logic [EW-1:0]    w_head;
  logic [4:0]       w_head_a;
  logic [4:0]       w_head_b;
  logic [1:0]       w_head_mode;
  logic [2:0]       w_head_op;
  logic [TAG_W-1:0] w_head_tag;

  assign w_wr_entry = {cmd_tag, cmd_op, cmd_mode, cmd_b, cmd_a};
  assign w_head     = r_mem[r_rd_ptr];
  assign {w_head_tag, w_head_op, w_head_mode, w_head_b, w_head_a} = w_head;

  // cmd_ready depends on the count only, so a full FIFO never accepts, even
  // in the cycle it is popped.
  assign cmd_ready  = (r_count != CW'(DEPTH));
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE) || (r_count != '0);

  // FIFO storage carries no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_state   <= S_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_en    <= 1'b0;
      alu_a_op  <= '0;
      alu_b_op  <= '0;
      alu_a_en  <= 1'b0;
      alu_b_en  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // FIFO bookkeeping
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // ALU pins are zero unless the next cycle is ISSUE; ISSUE lasts exactly
      // one cycle, so this default also clears them on entry to CAPTURE.
      alu_a    <= '0;
      alu_b    <= '0;
      alu_en   <= 1'b0;
      alu_a_op <= '0;
      alu_b_op <= '0;
      alu_a_en <= 1'b0;
      alu_b_en <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            rsp_tag <= w_head_tag;
            case (w_head_mode)
              2'b01: begin
                alu_en   <= 1'b1;
                alu_a_en <= 1'b1;
                alu_a_op <= w_head_op;
                alu_a    <= w_head_a;
                alu_b    <= w_head_b;
                r_state  <= S_ISSUE;
              end
              2'b10: begin
                alu_en   <= 1'b1;
                alu_b_en <= 1'b1;
                alu_b_op <= w_head_op[1:0];
                alu_a    <= w_head_a;
                alu_b    <= w_head_b;
                r_state  <= S_ISSUE;
              end
              2'b00: begin
                rsp_data  <= '0;
                rsp_err   <= 1'b0;
                rsp_valid <= 1'b1;
                r_state   <= S_RESP;
              end
              default: begin
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                r_state   <= S_RESP;
              end
            endcase
          end
        end
        S_ISSUE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // The ALU registers its result on the ISSUE edge; it is valid now.
          rsp_data  <= alu_res;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          r_state   <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
// Testbench for alu_cmd_sequencer. A behavioural ALU stub answers the DUT's
// pins. A command-level reference model predicts each response from the
// command alone.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [4:0]       cmd_a;
  logic [4:0]       cmd_b;
  logic [1:0]       cmd_mode;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [4:0]       alu_a;
  logic [4:0]       alu_b;
  logic             alu_en;
  logic [2:0]       alu_a_op;
  logic [1:0]       alu_b_op;
  logic             alu_a_en;
  logic             alu_b_en;
  logic [5:0]       alu_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [5:0]       rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
  logic             busy;
  logic [2:0]       fifo_count;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode), .cmd_op(cmd_op),
    .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_en(alu_en),
    .alu_a_op(alu_a_op), .alu_b_op(alu_b_op),
    .alu_a_en(alu_a_en), .alu_b_en(alu_b_en), .alu_res(alu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] mode;
    logic [2:0] op;
    logic [3:0] tag;
  } cmd_t;

  cmd_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   en_cnt = 0;
  int   en_seen = 0;
  logic [16:0] last_pins = '0;

  // ALU semantics used by both the stub and the reference model.
  function automatic logic [5:0] f_a(input logic [2:0] op,
                                     input logic signed [4:0] a,
                                     input logic signed [4:0] b);
    logic signed [5:0] sa, sb, r;
    sa = a; sb = b;
    case (op)
      3'd0:    r = sa + sb;
      3'd1:    r = sa - sb;
      3'd2:    r = sa & sb;
      3'd3:    r = sa | sb;
      3'd4:    r = sa ^ sb;
      3'd5:    r = ~sa;
      3'd6:    r = sa;
      default: r = sb;
    endcase
    return r;
  endfunction

  function automatic logic [5:0] f_b(input logic [1:0] op,
                                     input logic signed [4:0] a,
                                     input logic signed [4:0] b);
    logic signed [5:0] sa, sb, r;
    sa = a; sb = b;
    case (op)
      2'd0:    r = sa - sb;
      2'd1:    r = sa + sb;
      2'd2:    r = -sa;
      default: r = -sb;
    endcase
    return r;
  endfunction

  // {err, data} expected for a command.
  function automatic logic [6:0] ref_rsp(input cmd_t c);
    case (c.mode)
      2'b01:   return {1'b0, f_a(c.op, c.a, c.b)};
      2'b10:   return {1'b0, f_b(c.op[1:0], c.a, c.b)};
      2'b00:   return 7'h00;
      default: return 7'h40;
    endcase
  endfunction

  // Registered ALU stub; garbage when not enabled exposes mistimed captures.
  always @(posedge clk) begin
    if (alu_en) begin
      if (alu_a_en)      alu_res <= f_a(alu_a_op, alu_a, alu_b);
      else if (alu_b_en) alu_res <= f_b(alu_b_op, alu_a, alu_b);
      else               alu_res <= 6'h2A;
    end else begin
      alu_res <= 6'($urandom);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (alu_en) begin
      en_cnt    <= en_cnt + 1;
      last_pins <= {alu_a_en, alu_b_en, alu_a_op, alu_b_op, alu_a, alu_b};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Offer one command at the current negedge; leaves cmd_valid asserted.
  task automatic push(input logic [4:0] a, input logic [4:0] b,
                      input logic [1:0] mode, input logic [2:0] op,
                      input logic [3:0] tag, input bit exp_acc, output int t);
    cmd_t c;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_mode = mode; cmd_op = op; cmd_tag = tag;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_acc));
    if (exp_acc) begin
      c.a = a; c.b = b; c.mode = mode; c.op = op; c.tag = tag;
      exp_q.push_back(c);
    end
    @(posedge clk);
    @(negedge clk);
    t = cyc;
  endtask

  // Wait for the next response, check it against the model, then consume it
  // after 'stall' cycles of rsp_ready=0. exp_lat < 0 skips the latency check.
  task automatic collect(input int stall, input bit keep_ready,
                         input int exp_lat, input int t_ref);
    cmd_t c;
    logic [6:0]  e_rsp;
    logic [16:0] e_pins;
    bit          is_alu;
    int          k;
    rsp_ready = (stall == 0);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_valid_rise", 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("model_queue_nonempty", 32'd0, 32'd1);
      return;
    end
    c = exp_q.pop_front();
    e_rsp  = ref_rsp(c);
    is_alu = (c.mode == 2'b01) || (c.mode == 2'b10);
    e_pins = (c.mode == 2'b01) ? {2'b10, c.op, 2'b00, c.a, c.b}
                               : {2'b01, 3'b000, c.op[1:0], c.a, c.b};
    if (exp_lat >= 0) chk("latency", 32'(cyc - t_ref), 32'(exp_lat));
    chk("rsp_data", 32'(rsp_data), 32'(e_rsp[5:0]));
    chk("rsp_tag", 32'(rsp_tag), 32'(c.tag));
    chk("rsp_err", 32'(rsp_err), 32'(e_rsp[6]));
    chk("alu_en_cycles", 32'(en_cnt - en_seen), is_alu ? 32'd1 : 32'd0);
    if (is_alu) chk("alu_pins", 32'(last_pins), 32'(e_pins));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("rsp_hold", 32'({rsp_valid, rsp_err, rsp_tag, rsp_data}),
          32'({1'b1, e_rsp[6], c.tag, e_rsp[5:0]}));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    rsp_ready = keep_ready;
    en_seen = en_cnt;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu"}, 32'({alu_a, alu_b, alu_en, alu_a_op, alu_b_op, alu_a_en, alu_b_en}), 32'd0);
    chk({tag, "_rsp"}, 32'({rsp_valid, rsp_data, rsp_tag, rsp_err, busy, fifo_count}), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   k;
    bit   seen;
    logic [4:0] ra, rb;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_mode = '0;
    cmd_op = '0; cmd_tag = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    en_seen = en_cnt;

    // A-group add 7 + 5, tag 3
    push(5'd7, 5'd5, 2'b01, 3'd0, 4'd3, 1'b1, t);
    cmd_valid = 1'b0;
    collect(0, 1'b1, 3, t);
    chk("add_const", 32'(rsp_data), 32'd12);

    // -16 + -16 and B-group 3 + -4
    push(5'b10000, 5'b10000, 2'b01, 3'd0, 4'd1, 1'b1, t);
    cmd_valid = 1'b0;
    collect(0, 1'b1, 3, t);
    chk("add_neg_const", 32'(rsp_data), 32'h20);
    push(5'd3, 5'b11100, 2'b10, 3'd1, 4'd2, 1'b1, t);
    cmd_valid = 1'b0;
    collect(0, 1'b1, 3, t);
    chk("bgrp_const", 32'(rsp_data), 32'h3F);

    // Fill: one held in RESP plus DEPTH queued, sixth refused
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ra = 5'($urandom); rb = 5'($urandom);
      push(ra, rb, 2'b01, 3'($urandom_range(0, 7)), 4'(i), i < 5, t);
    end
    cmd_valid = 1'b0;
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_busy", 32'(busy), 32'd1);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    collect(0, 1'b0, -1, 0);
    chk("full_ready_before_pop", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("full_ready_after_pop", 32'(cmd_ready), 32'd1);
    for (int i = 1; i < 5; i++) collect(0, 1'b1, -1, 0);

    // Illegal then nop
    push(5'd9, 5'd4, 2'b11, 3'd2, 4'd9, 1'b1, t);
    cmd_valid = 1'b0;
    collect(0, 1'b1, 1, t);
    push(5'd1, 5'd2, 2'b00, 3'd0, 4'd5, 1'b1, t);
    cmd_valid = 1'b0;
    collect(0, 1'b1, 1, t);

    // rsp_ready 0,0,1 with exactly one response consumed
    push(5'd11, 5'd6, 2'b01, 3'd1, 4'd7, 1'b1, t);
    cmd_valid = 1'b0;
    collect(2, 1'b1, -1, 0);
    repeat (3) @(negedge clk);
    chk("single_consume_valid", 32'(rsp_valid), 32'd0);
    chk("single_consume_busy", 32'(busy), 32'd0);

    // Randomized bursts against the reference model
    for (int it = 0; it < 30; it++) begin
      rsp_ready = 1'b0;
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        push(5'($urandom), 5'($urandom), 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 4'($urandom), 1'b1, t);
      end
      cmd_valid = 1'b0;
      for (int j = 0; j < k; j++) collect($urandom_range(0, 2), 1'b0, -1, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("random_idle", 32'(busy), 32'd0);

    // Reset during ISSUE with two entries queued
    rsp_ready = 1'b0;
    push(5'd2, 5'd3, 2'b01, 3'd0, 4'd0, 1'b1, t);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_resp", 32'(rsp_valid), 32'd1);
    push(5'd4, 5'd5, 2'b01, 3'd1, 4'd1, 1'b1, t);
    push(5'd6, 5'd7, 2'b10, 3'd2, 4'd2, 1'b1, t);
    push(5'd8, 5'd9, 2'b01, 3'd3, 4'd3, 1'b1, t);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_issue", 32'(alu_en), 32'd1);
    chk("pre_reset_count", 32'(fifo_count), 32'd2);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    en_seen = en_cnt;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("post_reset_no_rsp", 32'(seen), 32'd0);
    chk("post_reset_no_issue", 32'(en_cnt - en_seen), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator-side driver for the 5-bit signed ALU.
- Accepts operation commands over a valid/ready interface and buffers them in a small FIFO.
- Issues one operation at a time to the ALU pins, captures the registered ALU result, and returns it with the command tag over a valid/ready response interface.
- Sits between the test/control logic and the ALU instance.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2).
- TAG_W, 4, width of the command/response tag.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_a  in  5  signed operand A.
- cmd_b  in  5  signed operand B.
- cmd_mode  in  2  operation group: 01 = A-group, 10 = B-group, 00 = nop, 11 = illegal.
- cmd_op  in  3  opcode; B-group uses cmd_op[1:0].
- cmd_tag  in  TAG_W  user tag.
- alu_a, alu_b  out  5  operands to ALU.
- alu_en  out  1  ALU enable.
- alu_a_op  out  3  ALU A-group opcode.
- alu_b_op  out  2  ALU B-group opcode.
- alu_a_en, alu_b_en  out  1  group enables.
- alu_res  in  6  signed registered ALU result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response accepted.
- rsp_data  out  6  captured result.
- rsp_tag  out  TAG_W  tag of the completed command.
- rsp_err  out  1  command had illegal mode.
- busy  out  1  FSM not in IDLE or FIFO non-empty.
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. On reset:
  - All outputs are 0, except cmd_ready = 1.
  - FIFO is emptied and FSM enters IDLE.
  - Any in-flight operation or pending response is discarded; no rsp_valid follows.
- FIFO push when cmd_valid && cmd_ready. cmd_ready = (fifo_count != DEPTH), combinational from count.
- Pop and push in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- Data written while full is dropped and never enqueued.
- All ALU-side outputs are registered. Outside ISSUE: alu_en = alu_a_en = alu_b_en = 0; alu_a, alu_b and the ops are 0.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: if FIFO non-empty, pop the head entry.
  - mode 01 → ISSUE with alu_a_en = 1, alu_b_en = 0, alu_a_op = cmd_op.
  - mode 10 → ISSUE with alu_a_en = 0, alu_b_en = 1, alu_b_op = cmd_op[1:0].
  - mode 00 → RESP directly with rsp_data = 0, rsp_err = 0.
  - mode 11 → RESP directly with rsp_data = 0, rsp_err = 1.
  - ALU pins never toggle for nop or illegal commands.
- ISSUE (exactly 1 cycle): alu_en = 1 with operands and ops driven. Next state is CAPTURE.
- CAPTURE (1 cycle): ALU pins return to 0. At the end of this cycle, alu_res is registered into rsp_data, rsp_err = 0, and rsp_tag holds the popped tag. Next state is RESP.
- RESP: rsp_valid = 1. rsp_data, rsp_tag and rsp_err remain stable until rsp_valid && rsp_ready; then go to IDLE with rsp_valid = 0 on the next cycle.
- No pop occurs in RESP. Commands continue to be accepted into the FIFO while FSM is in RESP.
- Latency from FIFO head to rsp_valid:
  - ALU ops: 3 cycles (IDLE pop, ISSUE, CAPTURE, then RESP).
  - nop/illegal: 1 cycle.
- Minimum issue spacing with rsp_ready held high: one ALU op per 4 cycles.
- busy = (state != IDLE) || (fifo_count != 0).
- Simultaneous cmd push and IDLE pop with fifo_count == 1: the new entry remains; count stays 1.

Test Plan:
- Reset released, cmd A-group op0, a=7, b=5, tag=3, rsp_ready=1 → one ISSUE cycle with alu_en=1, alu_a_en=1, alu_a_op=0; rsp_valid 3 cycles after pop with rsp_data=12, rsp_tag=3, rsp_err=0.
- Cmd A-group op0, a=-16, b=-16 → rsp_data=6'b100000 (-32); cmd B-group op1, a=3, b=-4 → alu_b_en=1, alu_b_op=1, rsp_data=6'h3F (-1).
- rsp_ready=0, stream 6 commands back-to-back → 1 held in RESP plus DEPTH=4 queued; cmd_ready=0 after the 5th accept, 6th not accepted. Release rsp_ready → responses in order with tags 0..4; cmd_ready reasserts after the next pop.
- Cmd mode 11, tag=9 → alu_en never asserted; rsp_valid 1 cycle after pop with rsp_err=1, rsp_data=0, rsp_tag=9. Mode 00 → rsp_err=0, rsp_data=0.
- rsp_valid held with rsp_ready toggling 0,0,1 → rsp_data and rsp_tag stable until the handshake; exactly one response consumed.
- rst_n asserted during ISSUE with 2 entries queued → all outputs 0 asynchronously, fifo_count=0, busy=0; no response after release.
